// File: rtl/fetch_icache.sv
// rtl/fetch_icache.sv - instruction fetch PC register with a direct-mapped, line-refill instruction cache
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable                advance PCF when the fetched instruction is valid
//   PCSrcE, JALRinstrE    redirect request and target select (ALUResultE vs PCTargetE)
//   ALUResultE, PCTargetE redirect targets
//   flush                 invalidate every cached line
//   mem_req/mem_addr      refill beat request and its word address (held until mem_ack)
//   mem_ack/mem_rdata     beat accepted and its data
//   instrF/instr_valid    instruction at PCF and its qualifier
//   PCF/PCPlus4F          fetch PC and PC+4
//   hit_count/miss_count  free-running wrapping lookup statistics
module fetch_icache #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SETS       = 16,
    parameter int                    LINE_WORDS = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  PCSrcE,
    input  logic                  JALRinstrE,
    input  logic [DATA_WIDTH-1:0] ALUResultE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instrF,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] PCPlus4F,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int BEAT_W  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = DATA_WIDTH - TAG_LSB;

    typedef enum logic {LOOKUP, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, next_pc;
    logic [DATA_WIDTH-1:0]   base_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    poison_q;
    logic [SETS-1:0]         valid_q;
    logic [31:0]             hit_cnt_q, miss_cnt_q;
    logic [TAG_W-1:0]        tag_q  [SETS];
    logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];

    logic [IDX_W-1:0]        idx, refill_idx;
    logic [TAG_W-1:0]        tag, refill_tag;
    logic [BEAT_W-1:0]       off;
    logic                    hit, last_beat, refill_done, pc_load;
    logic [DATA_WIDTH-1:0]   line_mask;

    assign idx        = pc_q[IDX_LSB +: IDX_W];
    assign tag        = pc_q[TAG_LSB +: TAG_W];
    assign refill_idx = base_q[IDX_LSB +: IDX_W];
    assign refill_tag = base_q[TAG_LSB +: TAG_W];
    assign line_mask  = DATA_WIDTH'(LINE_WORDS * 4 - 1);

    generate
        if (OFF_W > 0) begin : g_off
            assign off = pc_q[2 +: BEAT_W];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    assign hit         = (state_q == LOOKUP) && valid_q[idx] && (tag_q[idx] == tag);
    assign instr_valid = hit;
    assign instrF      = hit ? data_q[idx][off] : '0;

    // Beat address only moves on an ack, so request and address are stable while memory stalls.
    assign mem_req     = (state_q == REFILL);
    assign mem_addr    = base_q + (DATA_WIDTH'(beat_q) << 2);
    assign last_beat   = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign refill_done = (state_q == REFILL) && mem_ack && last_beat;

    assign next_pc  = PCSrcE ? (JALRinstrE ? {ALUResultE[DATA_WIDTH-1:1], 1'b0} : PCTargetE)
                             : pc_q + DATA_WIDTH'(4);
    assign pc_load  = PCSrcE || (enable && hit);
    assign PCF      = pc_q;
    assign PCPlus4F = pc_q + DATA_WIDTH'(4);

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOOKUP: if (!hit)       state_d = REFILL;
            REFILL: if (refill_done) state_d = LOOKUP;
            default:                state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LOOKUP;
            pc_q       <= RESET_PC;
            base_q     <= '0;
            beat_q     <= '0;
            poison_q   <= 1'b0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load) pc_q <= next_pc;
            if (hit && enable) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == LOOKUP && !hit) begin
                base_q     <= pc_q & ~line_mask;
                beat_q     <= '0;
                poison_q   <= 1'b0;
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (state_q == REFILL) begin
                if (mem_ack) beat_q <= beat_q + BEAT_W'(1);
                // A flush seen mid-refill means the incoming line may be stale; never mark it valid.
                if (flush) poison_q <= 1'b1;
            end
            if (flush) begin
                valid_q <= '0;
            end else if (refill_done && !poison_q) begin
                valid_q[refill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; validity alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_ack) begin
            data_q[refill_idx][beat_q] <= mem_rdata;
            if (last_beat) tag_q[refill_idx] <= refill_tag;
        end
    end

endmodule

// File: tb/tb_fetch_icache.sv
// tb/tb_fetch_icache.sv - self-checking bench for fetch_icache against a line-level cache model
module tb_fetch_icache;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, PCSrcE, JALRinstrE, flush, mem_ack;
    logic [31:0] ALUResultE, PCTargetE, mem_rdata;
    logic        mem_req, instr_valid;
    logic [31:0] mem_addr, instrF, PCF, PCPlus4F, hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    // Model: memory contents, cached line directory, refill in progress, PC, counters.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    bit          m_ref, m_poison, m_hit;
    logic [31:0] m_base, m_pc, m_hits, m_misses;
    int          m_beat;

    fetch_icache #(.DATA_WIDTH(32), .SETS(16), .LINE_WORDS(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .PCSrcE(PCSrcE), .JALRinstrE(JALRinstrE),
        .ALUResultE(ALUResultE), .PCTargetE(PCTargetE), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instrF(instrF), .instr_valid(instr_valid), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) & 32'hF);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_ref = 1'b0; m_poison = 1'b0; m_beat = 0; m_base = '0;
        m_pc = 32'h0; m_hits = '0; m_misses = '0;
    endtask

    // One clock: compare DUT against model, apply inputs, advance the model, step to next negedge.
    task automatic cyc(input bit en, input bit psrc, input bit jalr, input logic [31:0] alu,
                       input logic [31:0] tgt, input bit fl, input bit ack);
        logic [31:0] npc;
        int s;
        s     = set_of(m_pc);
        m_hit = !m_ref && m_valid[s] && (m_tag[s] == m_pc[31:8]);
        check("instr_valid", {31'd0, instr_valid}, {31'd0, m_hit});
        check("instrF", instrF, m_hit ? memfn(m_pc & ~32'h3) : 32'h0);
        check("PCF", PCF, m_pc);
        check("PCPlus4F", PCPlus4F, m_pc + 32'd4);
        check("mem_req", {31'd0, mem_req}, {31'd0, m_ref});
        if (m_ref) check("mem_addr", mem_addr, m_base + 32'(4 * m_beat));
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);

        enable = en; PCSrcE = psrc; JALRinstrE = jalr; ALUResultE = alu; PCTargetE = tgt;
        flush = fl; mem_ack = ack;
        mem_rdata = m_ref ? memfn(m_base + 32'(4 * m_beat)) : $urandom;

        npc = psrc ? (jalr ? (alu & ~32'h1) : tgt) : m_pc + 32'd4;
        if (!m_ref) begin
            if (m_hit && en) m_hits++;
            if (!m_hit) begin
                m_misses++; m_ref = 1'b1; m_base = m_pc & ~32'hF; m_beat = 0; m_poison = 1'b0;
            end
        end else begin
            if (ack) begin
                if (m_beat == 3) begin
                    m_ref = 1'b0;
                    m_tag[set_of(m_base)] = m_base[31:8];
                    if (!m_poison) m_valid[set_of(m_base)] = 1'b1;
                end else begin
                    m_beat++;
                end
            end
            if (fl) m_poison = 1'b1;
        end
        if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        if (psrc || (en && m_hit)) m_pc = npc;

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; enable = 0; PCSrcE = 0; JALRinstrE = 0; flush = 0; mem_ack = 0;
        ALUResultE = '0; PCTargetE = '0; mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_PCF", PCF, 32'h0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        reset = 1'b1;

        // Cold miss at 0, 4-beat refill, 4 sequential hits, then miss at 0x10.
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 1);
        check("seq_hits", hit_count, 32'd4);
        check("seq_misses", miss_count, 32'd2);
        check("seq_refill_addr", mem_addr, 32'h10);

        // Memory stall: request and address hold, PC holds.
        for (int i = 0; i < 10; i++) begin
            check("stall_req", {31'd0, mem_req}, 32'd1);
            check("stall_addr", mem_addr, 32'h10);
            cyc(1, 0, 0, 0, 0, 0, 0);
        end
        check("stall_pc", PCF, 32'h10);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);

        // Redirects: JALR clears bit 0, branch target, redirect during refill.
        cyc(0, 1, 1, 32'h25, 32'h0, 0, 0);
        check("jalr_pc", PCF, 32'h24);
        cyc(0, 1, 0, 32'h0, 32'h40, 0, 0);
        check("br_pc", PCF, 32'h40);
        check("br_refill_addr", mem_addr, 32'h20);
        cyc(0, 1, 0, 32'h0, 32'h28, 0, 0);
        check("redir_refill_pc", PCF, 32'h28);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("redir_installed", {31'd0, instr_valid}, 32'd1);
        check("redir_instr", instrF, memfn(32'h28));

        // Flush of a cached line, then flush during the refill of that line.
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("flush_miss", {31'd0, instr_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("flush_refill_miss", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("reinstalled", {31'd0, instr_valid}, 32'd1);

        // Reset after two beats of a refill.
        cyc(0, 1, 0, 0, 32'h104, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_pc", PCF, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 32'h104, 0, 0);
        check("post_rst_miss", {31'd0, instr_valid}, 32'd0);

        // Randomized traffic over a small address window so lines alias and get reused.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
                32'($urandom_range(0, 1023)), {20'd0, 10'($urandom_range(0, 1023)), 2'b00},
                ($urandom_range(0, 49) == 0), $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_icache.md
FETCH_ICACHE -- requirements
Module: fetch_icache

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction/address width.
REQ-002 Parameter SETS, 16, cache lines, power of 2, >=2.
REQ-003 Parameter LINE_WORDS, 4, words per line, power of 2, >=1.
REQ-004 Parameter RESET_PC, 0, PCF value after reset.
REQ-005 The block SHALL use one clock, clk; reset is asynchronous, active-low, named reset.
REQ-006 Ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  async active-low reset
- enable  in  1  advance PC when instruction valid
- PCSrcE  in  1  redirect taken
- JALRinstrE  in  1  redirect target from ALUResultE
- ALUResultE  in  DATA_WIDTH  JALR target
- PCTargetE  in  DATA_WIDTH  branch/JAL target
- flush  in  1  invalidate all lines (fence.i)
- mem_req  out  1  refill beat request
- mem_addr  out  DATA_WIDTH  word address of beat
- mem_ack  in  1  beat accepted, mem_rdata valid
- mem_rdata  in  DATA_WIDTH  beat data
- instrF  out  DATA_WIDTH  instruction at PCF
- instr_valid  out  1  instrF valid this cycle
- PCF  out  DATA_WIDTH  fetch PC
- PCPlus4F  out  DATA_WIDTH  PCF+4
- hit_count  out  32  lookup hits
- miss_count  out  32  lookup misses

Function
REQ-007 PCF address split SHALL be: bits[1:0] ignored; offset = next log2(LINE_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-008 Storage SHALL be direct-mapped: per line, a valid bit, a tag and LINE_WORDS data words; reads are combinational.
REQ-009 FSM states SHALL be LOOKUP and REFILL.
REQ-010 In LOOKUP: hit = valid[index] && tag match; instr_valid = hit; instrF = addressed word on a hit, 0 otherwise.
REQ-011 In LOOKUP on a miss, the block SHALL go to REFILL next cycle, latching the line base address (PCF with offset and bits[1:0] zeroed), beat counter = 0.
REQ-012 In REFILL, the block SHALL drive mem_req=1 with mem_addr = base + 4*beat.
- On mem_ack: write mem_rdata to word[beat] and increment beat.
- On the ack of beat LINE_WORDS-1: write the tag, set valid, return to LOOKUP.
- instr_valid=0 throughout REFILL.
REQ-013 mem_req and mem_addr SHALL remain stable until mem_ack; memory latency is unbounded.
REQ-014 Next PC SHALL be:
- PCSrcE=1 and JALRinstrE=1: ALUResultE with bit0 cleared.
- PCSrcE=1 and JALRinstrE=0: PCTargetE.
- Otherwise: PCF+4, modulo 2^DATA_WIDTH.
REQ-015 PCF SHALL load next PC when PCSrcE=1 (any state, regardless of enable), or when enable=1 and instr_valid=1; otherwise PCF holds.
REQ-016 A redirect during REFILL SHALL NOT abort the refill; the line completes and installs, then LOOKUP uses the updated PCF.
REQ-017 PCPlus4F SHALL equal PCF+4 combinationally.
REQ-018 flush=1 SHALL clear all valid bits at the clock edge.
REQ-019 If flush occurs during REFILL, the refill SHALL complete, but its valid bit is not set; if flush coincides with the final ack, flush wins.
REQ-020 hit_count SHALL increment on each LOOKUP-state cycle with hit=1 and enable=1.
REQ-021 miss_count SHALL increment once per LOOKUP->REFILL transition.
REQ-022 Both counters SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-023 While reset=0, the block SHALL set:
- PCF=RESET_PC.
- State LOOKUP, all valid bits 0, beat 0.
- mem_req=0, instr_valid=0.
- hit_count=miss_count=0.
REQ-024 Reset asserted mid-REFILL SHALL abandon the refill with no line valid; data/tag arrays need no reset.

Verification
REQ-025 The bench SHALL cover:
- Reset release with RESET_PC=0 -> cycle 0 instr_valid=0; cycle 1 mem_req=1, mem_addr=0x0; after 4 acks, next cycle instr_valid=1, instrF=mem[0x0]; miss_count=1.
- Sequential 0x0..0xC with enable=1 -> 4 consecutive hits, PCF increments by 4 each cycle, hit_count=4; 0x10 misses -> refill from 0x10.
- mem_ack held low 10 cycles in REFILL -> mem_req=1 and mem_addr constant all 10 cycles; PCF unchanged.
- PCSrcE=1, JALRinstrE=1, ALUResultE=0x25 -> PCF=0x24 next cycle; with JALRinstrE=0, PCTargetE=0x40 -> PCF=0x40; redirect during REFILL -> line still installed, lookup at new PC.
- flush pulse after a line is cached -> re-access to the same PC misses; flush during REFILL -> same line misses again after completion.
- reset=0 mid-REFILL (after beat 2) -> mem_req=0 immediately, PCF=RESET_PC; post-reset access to that line misses.
